// File: rtl/riscv_fetch_q.sv
// Instruction fetch front end: in-order icache requests, prefetch queue, redirect drop counter.
// Optional FETCH_BYPASS_EN presents a response to decode in its arrival cycle when the queue is empty.
module riscv_fetch_q #(
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_branch_i,
  input  logic [31:0] fetch_branch_pc_i,
  input  logic        fetch_accept_i,
  input  logic        icache_accept_i,
  input  logic        icache_valid_i,
  input  logic        icache_error_i,
  input  logic [31:0] icache_inst_i,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_instr_o,
  output logic [31:0] fetch_pc_o,
  output logic        fetch_fault_o,
  output logic        icache_rd_o,
  output logic [31:0] icache_pc_o,
  output logic        icache_flush_o,
  output logic        icache_invalidate_o
);

  localparam logic [31:0] INST_FAULT = 32'h0000_0000;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } entry_t;

  logic          active_q, active_d;
  logic [31:0]   pc_q, pc_d;
  logic [OW-1:0] out_q, out_d;
  logic [OW-1:0] drop_q, drop_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [TW-1:0] trd_q, trd_d;
  logic [TW-1:0] twr_q, twr_d;

  entry_t      fifo_q [FIFO_DEPTH];
  logic [31:0] tag_q  [MAX_OUTSTANDING];

  logic [31:0] req_pc;
  logic        credit, req_rd, req_fire;
  logic        rsp, byp, valid, push, pop;
  entry_t      rsp_e, head;

  function automatic logic [TW-1:0] tnext(input logic [TW-1:0] p);
    return (int'(p) == MAX_OUTSTANDING - 1) ? '0 : p + TW'(1);
  endfunction

  always_comb begin
    req_pc   = (fetch_branch_i ? fetch_branch_pc_i : pc_q) & 32'hFFFF_FFFC;
    // stale in-flight responses will be dropped, so they hold no queue slot
    credit   = fetch_branch_i |
               ((int'(cnt_q) + int'(out_q) - int'(drop_q)) < FIFO_DEPTH);
    req_rd   = (active_q | fetch_branch_i) &
               (int'(out_q) < MAX_OUTSTANDING) & credit;
    req_fire = req_rd & icache_accept_i;
    rsp      = icache_valid_i & (out_q != '0);
    rsp_e    = '{pc:    tag_q[trd_q],
                 instr: icache_error_i ? INST_FAULT : icache_inst_i,
                 fault: icache_error_i};
`ifdef FETCH_BYPASS_EN
    byp      = rsp & (cnt_q == '0) & (drop_q == '0) & ~fetch_branch_i;
`else
    byp      = 1'b0;
`endif
    valid    = ((cnt_q != '0) | byp) & ~fetch_branch_i;
    head     = (cnt_q != '0) ? fifo_q[rd_q] : rsp_e;
    pop      = valid & fetch_accept_i & (cnt_q != '0);
    push     = rsp & (drop_q == '0) & ~fetch_branch_i &
               ~(byp & fetch_accept_i);
  end

  always_comb begin
    active_d = active_q | fetch_branch_i;
    pc_d     = pc_q;
    if (req_fire)
      pc_d = req_pc + 32'd4;
    else if (fetch_branch_i)
      pc_d = req_pc;
    out_d  = out_q + OW'(req_fire) - OW'(rsp);
    drop_d = drop_q;
    if (fetch_branch_i)
      drop_d = out_q - OW'(rsp);
    else if (rsp && drop_q != '0)
      drop_d = drop_q - OW'(1);
    twr_d = req_fire ? tnext(twr_q) : twr_q;
    trd_d = rsp ? tnext(trd_q) : trd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    wr_d  = wr_q + PW'(push);
    rd_d  = rd_q + PW'(pop);
    if (fetch_branch_i) begin
      cnt_d = '0;
      wr_d  = '0;
      rd_d  = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      pc_q     <= '0;
      out_q    <= '0;
      drop_q   <= '0;
      cnt_q    <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      trd_q    <= '0;
      twr_q    <= '0;
    end else begin
      active_q <= active_d;
      pc_q     <= pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      trd_q    <= trd_d;
      twr_q    <= twr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push)
      fifo_q[wr_q] <= rsp_e;
    if (req_fire)
      tag_q[twr_q] <= req_pc;
  end

  assign fetch_valid_o       = valid;
  assign fetch_pc_o          = valid ? head.pc : '0;
  assign fetch_instr_o       = valid ? head.instr : '0;
  assign fetch_fault_o       = valid & head.fault;
  assign icache_rd_o         = req_rd;
  assign icache_pc_o         = req_pc;
  assign icache_flush_o      = 1'b0;
  assign icache_invalidate_o = 1'b0;

endmodule

// File: tb/tb_riscv_fetch_q.sv
// Randomized bench for riscv_fetch_q against a queue-based reference model.
// Honours FETCH_BYPASS_EN the same way as the design.
module tb_riscv_fetch_q;

  localparam int FD = 4;
  localparam int MO = 2;
  localparam logic [31:0] INST_FAULT = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_branch_i = 1'b0;
  logic [31:0] fetch_branch_pc_i = '0;
  logic        fetch_accept_i = 1'b0;
  logic        icache_accept_i = 1'b0;
  logic        icache_valid_i = 1'b0;
  logic        icache_error_i = 1'b0;
  logic [31:0] icache_inst_i = '0;
  logic        fetch_valid_o;
  logic [31:0] fetch_instr_o;
  logic [31:0] fetch_pc_o;
  logic        fetch_fault_o;
  logic        icache_rd_o;
  logic [31:0] icache_pc_o;
  logic        icache_flush_o;
  logic        icache_invalidate_o;

  riscv_fetch_q #(.FIFO_DEPTH(FD), .MAX_OUTSTANDING(MO)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .fetch_branch_i     (fetch_branch_i),
    .fetch_branch_pc_i  (fetch_branch_pc_i),
    .fetch_accept_i     (fetch_accept_i),
    .icache_accept_i    (icache_accept_i),
    .icache_valid_i     (icache_valid_i),
    .icache_error_i     (icache_error_i),
    .icache_inst_i      (icache_inst_i),
    .fetch_valid_o      (fetch_valid_o),
    .fetch_instr_o      (fetch_instr_o),
    .fetch_pc_o         (fetch_pc_o),
    .fetch_fault_o      (fetch_fault_o),
    .icache_rd_o        (icache_rd_o),
    .icache_pc_o        (icache_pc_o),
    .icache_flush_o     (icache_flush_o),
    .icache_invalidate_o(icache_invalidate_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  typedef struct {
    logic [31:0] pc;
    bit          stale;
  } req_t;

  ent_t        pq[$];
  req_t        fl[$];
  bit          m_active;
  logic [31:0] m_pc;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_hs    = 0;
  logic        got_rd, got_v;
  logic [31:0] got_ipc;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int live_cnt();
    int n = 0;
    foreach (fl[i]) if (!fl[i].stale) n++;
    return n;
  endfunction

  task automatic model_reset();
    pq.delete();
    fl.delete();
    m_active = 1'b0;
    m_pc     = '0;
  endtask

  task automatic do_reset();
    rst               = 1'b1;
    fetch_branch_i    = 1'b0;
    fetch_branch_pc_i = '0;
    fetch_accept_i    = 1'b0;
    icache_accept_i   = 1'b0;
    icache_valid_i    = 1'b0;
    icache_error_i    = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    chk("rst_valid", fetch_valid_o, 0);
    chk("rst_rd", icache_rd_o, 0);
    chk("rst_ipc", icache_pc_o, 0);
    chk("rst_pc", fetch_pc_o, 0);
    chk("rst_instr", fetch_instr_o, 0);
    chk("rst_fault", fetch_fault_o, 0);
    chk("rst_flush", icache_flush_o, 0);
    chk("rst_inval", icache_invalidate_o, 0);
    rst = 1'b0;
  endtask

  task automatic cycle(input bit br, input logic [31:0] bpc, input bit fa,
                       input bit ia, input int ivp, input int errp);
    bit          iv, err, byp, ex_rd, ex_v;
    logic [31:0] ex_ipc, inst;
    ent_t        re, ex_h;
    req_t        hd;
    @(negedge clk);
    iv   = (fl.size() > 0) && ($urandom_range(99) < ivp);
    err  = ($urandom_range(99) < errp);
    inst = $urandom;
    assert (!(iv && fl.size() == 0));
    fetch_branch_i    = br;
    fetch_branch_pc_i = bpc;
    fetch_accept_i    = fa;
    icache_accept_i   = ia;
    icache_valid_i    = iv;
    icache_error_i    = err;
    icache_inst_i     = inst;
    #1;
    ex_ipc = (br ? bpc : m_pc) & 32'hFFFF_FFFC;
    ex_rd  = (m_active || br) && fl.size() < MO &&
             (br || (pq.size() + live_cnt()) < FD);
    hd = '{pc: 32'h0, stale: 1'b1};
    if (iv) hd = fl.pop_front();
    re   = '{pc: hd.pc, instr: err ? INST_FAULT : inst, fault: err};
    byp  = BYP && iv && !hd.stale && pq.size() == 0 && !br;
    ex_v = !br && (pq.size() > 0 || byp);
    ex_h = (pq.size() > 0) ? pq[0] : re;
    got_rd  = icache_rd_o;
    got_v   = fetch_valid_o;
    got_ipc = icache_pc_o;
    chk("rd", icache_rd_o, ex_rd);
    chk("ipc", icache_pc_o, ex_ipc);
    chk("valid", fetch_valid_o, ex_v);
    if (ex_v) begin
      chk("pc", fetch_pc_o, ex_h.pc);
      chk("instr", fetch_instr_o, ex_h.instr);
      chk("fault", fetch_fault_o, ex_h.fault);
    end
    if (icache_rd_o && ia) n_hs++;
    if (br) begin
      pq.delete();
      foreach (fl[i]) fl[i].stale = 1'b1;
    end else begin
      if (pq.size() > 0 && fa) void'(pq.pop_front());
      if (iv && !hd.stale && !(byp && fa)) pq.push_back(re);
    end
    if (ex_rd && ia) begin
      fl.push_back('{pc: ex_ipc, stale: 1'b0});
      m_pc = ex_ipc + 32'd4;
    end else if (br) begin
      m_pc = ex_ipc;
    end
    m_active = m_active | br;
  endtask

  initial begin
    do_reset();
    repeat (10) cycle(0, 0, 1, 1, 0, 0);
    chk("idle_rd", got_rd, 0);

    cycle(1, 32'h8000_0000, 1, 1, 0, 0);
    repeat (40) cycle(0, 0, 1, 1, 70, 0);

    n_hs = 0;
    cycle(1, 32'h0000_1000, 0, 1, 100, 0);
    repeat (12) cycle(0, 0, 0, 1, 100, 0);
    chk("bp_reqs", n_hs, FD);
    chk("bp_stall", got_rd, 0);
    repeat (10) cycle(0, 0, 1, 1, 100, 0);

    cycle(1, 32'h0000_3000, 1, 1, 0, 0);
    cycle(0, 0, 1, 1, 0, 0);
    cycle(1, 32'h0000_0100, 1, 1, 0, 0);
    chk("redir_v", got_v, 0);
    repeat (20) cycle(0, 0, 1, 1, 50, 0);

    cycle(1, 32'h0000_3000, 1, 1, 0, 0);
    cycle(0, 0, 1, 1, 0, 0);
    cycle(1, 32'h0000_0400, 1, 1, 100, 0);
    repeat (15) cycle(0, 0, 1, 1, 60, 0);

    cycle(1, 32'h0000_0200, 1, 1, 0, 0);
    repeat (6) cycle(0, 0, 1, 1, 100, 100);

    cycle(1, 32'hFFFF_FFFC, 1, 1, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    chk("wrap_pc", got_ipc, 32'h0);
    repeat (10) cycle(0, 0, 1, 0, 100, 0);

    cycle(1, 32'h0000_0500, 1, 1, 0, 0);
    cycle(0, 0, 1, 0, 100, 0);
`ifdef FETCH_BYPASS_EN
    chk("bypass_v", got_v, 1);
`else
    chk("nobypass_v", got_v, 0);
`endif

    repeat (3000)
      cycle($urandom_range(99) < 3, $urandom, $urandom_range(99) < 70,
            $urandom_range(99) < 70, 50, 10);

    do_reset();
    repeat (5) cycle(0, 0, 1, 1, 0, 0);
    cycle(1, 32'h0000_0040, 1, 1, 0, 0);
    repeat (500)
      cycle($urandom_range(99) < 5, $urandom, $urandom_range(99) < 50,
            $urandom_range(99) < 80, 60, 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
